// File: rtl/regbank_arbiter_if.sv
// Bundles the core, debug and bank-side signals of the register-bank arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface regbank_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] core_RegLe1;
  logic [ADDR_W-1:0] core_RegLe2;
  logic [ADDR_W-1:0] core_RegEscr;
  logic              core_EscrReg;
  logic [DATA_W-1:0] core_datain;
  logic [DATA_W-1:0] core_data1;
  logic [DATA_W-1:0] core_data2;
  logic              core_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;

  logic [ADDR_W-1:0] bank_RegLe1;
  logic [ADDR_W-1:0] bank_RegLe2;
  logic [ADDR_W-1:0] bank_RegEscr;
  logic              bank_EscrReg;
  logic [DATA_W-1:0] bank_datain;
  logic [DATA_W-1:0] bank_data1;
  logic [DATA_W-1:0] bank_data2;

  modport master (
    output core_RegLe1, core_RegLe2, core_RegEscr, core_EscrReg, core_datain,
    input  core_data1, core_data2, core_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata,
    input  bank_RegLe1, bank_RegLe2, bank_RegEscr, bank_EscrReg, bank_datain,
    output bank_data1, bank_data2
  );

  modport slave (
    input  core_RegLe1, core_RegLe2, core_RegEscr, core_EscrReg, core_datain,
    output core_data1, core_data2, core_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata,
    output bank_RegLe1, bank_RegLe2, bank_RegEscr, bank_EscrReg, bank_datain,
    input  bank_data1, bank_data2
  );
endinterface

// File: rtl/regbank_arbiter.sv
// Shares the register bank between the core (pass-through) and a debug port whose
// reads stall the core for two cycles and whose writes steal a free slot or force one.
module regbank_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  regbank_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_CAPT  = 3'd2,
    WR_WAIT  = 3'd3,
    WR_FORCE = 3'd4,
    ACK      = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  wait_cnt_nxt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata;
  logic              dbg_wr_en;

  // r0 is architecturally zero, so debug writes to it complete without touching the bank.
  assign dbg_wr_en      = (lat_addr != '0);
  assign bus.core_data1 = bus.bank_data1;
  assign bus.core_data2 = bus.bank_data2;
  assign bus.dbg_rdata  = rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata     <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state == IDLE && bus.dbg_req) begin
        lat_addr  <= bus.dbg_addr;
        lat_wdata <= bus.dbg_wdata;
      end
      if (state == RD_CAPT) rdata <= bus.bank_data2;
    end
  end

  always_comb begin
    state_nxt        = state;
    wait_cnt_nxt     = wait_cnt;
    bus.core_stall   = 1'b0;
    bus.dbg_ack      = 1'b0;
    bus.bank_RegLe1  = bus.core_RegLe1;
    bus.bank_RegLe2  = bus.core_RegLe2;
    bus.bank_RegEscr = bus.core_RegEscr;
    bus.bank_EscrReg = bus.core_EscrReg;
    bus.bank_datain  = bus.core_datain;
    case (state)
      IDLE: begin
        if (bus.dbg_req) state_nxt = bus.dbg_we ? WR_WAIT : RD_ISSUE;
      end
      RD_ISSUE: begin
        bus.core_stall   = 1'b1;
        bus.bank_RegLe2  = lat_addr;
        bus.bank_EscrReg = 1'b0;
        state_nxt        = RD_CAPT;
      end
      RD_CAPT: begin
        // The core sees debug data on port 2 this cycle; its result is re-presented later.
        bus.core_stall   = 1'b1;
        bus.bank_EscrReg = 1'b0;
        state_nxt        = ACK;
      end
      WR_WAIT: begin
        if (!bus.core_EscrReg) begin
          bus.bank_EscrReg = dbg_wr_en;
          bus.bank_RegEscr = lat_addr;
          bus.bank_datain  = lat_wdata;
          state_nxt        = ACK;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
          if (wait_cnt == CNT_W'(STARVE_MAX - 1)) state_nxt = WR_FORCE;
        end
      end
      WR_FORCE: begin
        bus.core_stall   = 1'b1;
        bus.bank_EscrReg = dbg_wr_en;
        bus.bank_RegEscr = lat_addr;
        bus.bank_datain  = lat_wdata;
        state_nxt        = ACK;
      end
      ACK: begin
        bus.dbg_ack  = 1'b1;
        wait_cnt_nxt = '0;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_regbank_arbiter.sv
// Bench for regbank_arbiter: directed debug transactions plus randomized core/debug traffic
// compared every cycle against a transaction-level reference model and a bank model.
module tb_regbank_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int SM = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regbank_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  regbank_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // Bank with registered reads, reset contents r[i] = 4*i, r0 not writable.
  logic [DW-1:0] bank_mem [32];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) bank_mem[i] <= DW'(i * 4);
      bus.bank_data1 <= '0;
      bus.bank_data2 <= '0;
    end else begin
      bus.bank_data1 <= bank_mem[bus.bank_RegLe1];
      bus.bank_data2 <= bank_mem[bus.bank_RegLe2];
      if (bus.bank_EscrReg && bus.bank_RegEscr != '0) bank_mem[bus.bank_RegEscr] <= bus.bank_datain;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one outstanding debug transaction described by its age and progress.
  logic [DW-1:0] ref_regs [32];
  bit            m_known, m_busy, m_we, m_driven;
  int            m_step, m_keeps;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rval;
  logic [DW-1:0] m_rdata = '0;
  logic [AW-1:0] e_le1, e_le2, e_wa;
  logic          e_we, e_stall, e_ack;
  logic [DW-1:0] e_wd;
  int            e_kind;
  logic          o_ack, o_stall, o_bwe;
  logic [AW-1:0] o_bwa;
  logic [DW-1:0] o_bwd, o_rdata;

  task automatic model_expect();
    e_le1 = bus.core_RegLe1;  e_le2 = bus.core_RegLe2;  e_wa = bus.core_RegEscr;
    e_we = bus.core_EscrReg;  e_wd = bus.core_datain;
    e_stall = 1'b0;  e_ack = 1'b0;  e_kind = 0;
    if (m_busy && !m_we) begin
      if (m_step == 1) begin e_stall = 1'b1; e_le2 = m_addr; e_we = 1'b0; end
      else if (m_step == 2) begin e_stall = 1'b1; e_we = 1'b0; end
      else e_ack = 1'b1;
    end else if (m_busy) begin
      if (m_driven) e_ack = 1'b1;
      else if (m_keeps == SM || !bus.core_EscrReg) begin
        e_kind = 1;  e_stall = (m_keeps == SM);
        e_we = (m_addr != '0);  e_wa = m_addr;  e_wd = m_wdata;
      end else e_kind = 2;
    end
  endtask

  task automatic model_update();
    if (reset) begin
      m_known = 1'b1;  m_busy = 1'b0;  m_rdata = '0;
      for (int i = 0; i < 32; i++) ref_regs[i] = DW'(i * 4);
    end else if (m_known) begin
      if (m_busy && !m_we && m_step == 1) m_rval = ref_regs[m_addr];
      if (m_busy && !m_we && m_step == 2) m_rdata = m_rval;
      if (e_we && e_wa != '0) ref_regs[e_wa] = e_wd;
      if (!m_busy) begin
        if (bus.dbg_req) begin
          m_busy = 1'b1;  m_we = bus.dbg_we;  m_addr = bus.dbg_addr;  m_wdata = bus.dbg_wdata;
          m_step = 1;  m_keeps = 0;  m_driven = 1'b0;
        end
      end else if (e_ack) m_busy = 1'b0;
      else begin
        if (e_kind == 1) m_driven = 1'b1;
        else if (e_kind == 2) m_keeps++;
        m_step++;
      end
    end
  endtask

  // Called at a falling edge with inputs driven; checks mid-cycle, advances one clock.
  task automatic cycle();
    #2;
    model_expect();
    o_ack = bus.dbg_ack;  o_stall = bus.core_stall;  o_bwe = bus.bank_EscrReg;
    o_bwa = bus.bank_RegEscr;  o_bwd = bus.bank_datain;  o_rdata = bus.dbg_rdata;
    if (m_known) begin
      check_eq("bank_RegLe1", 32'(bus.bank_RegLe1), 32'(e_le1));
      check_eq("bank_RegLe2", 32'(bus.bank_RegLe2), 32'(e_le2));
      check_eq("bank_EscrReg", 32'(o_bwe), 32'(e_we));
      if (e_we) begin
        check_eq("bank_RegEscr", 32'(o_bwa), 32'(e_wa));
        check_eq("bank_datain", o_bwd, e_wd);
      end
      check_eq("core_stall", 32'(o_stall), 32'(e_stall));
      check_eq("dbg_ack", 32'(o_ack), 32'(e_ack));
      check_eq("dbg_rdata", o_rdata, m_rdata);
      check_eq("core_data1", bus.core_data1, bus.bank_data1);
      check_eq("core_data2", bus.core_data2, bus.bank_data2);
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic rand_core(input bit we);
    bus.core_RegLe1 = AW'($urandom);  bus.core_RegLe2 = AW'($urandom);
    bus.core_RegEscr = AW'($urandom);  bus.core_datain = $urandom;
    bus.core_EscrReg = we;
  endtask

  // One debug transaction from accept to ack, then an idle cycle with the request dropped.
  task automatic dbg_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit core_busy, output int lat, output int stalls,
                        output int dbg_wr, output int core_kept);
    lat = 0;  stalls = 0;  dbg_wr = 0;  core_kept = 0;
    bus.dbg_req = 1'b1;  bus.dbg_we = we;  bus.dbg_addr = a;  bus.dbg_wdata = d;
    rand_core(core_busy);
    if (core_busy) bus.core_RegEscr = 5'd7;
    cycle();
    do begin
      rand_core(core_busy);
      if (core_busy) bus.core_RegEscr = 5'd7;
      cycle();
      lat++;
      stalls += int'(o_stall);
      if (o_bwe && o_bwa == a) dbg_wr++;
      if (o_bwe && o_bwa == 5'd7 && !o_ack) core_kept++;
    end while (!o_ack && lat < 20);
    check_eq("ack_seen", 32'(o_ack), 32'd1);
    bus.dbg_req = 1'b0;
    rand_core(1'b0);
    cycle();
  endtask

  int lat, st, wr, kept, stall_sum, bias;
  logic [DW-1:0] rd_val;

  initial begin
    reset = 1'b1;
    bus.dbg_req = 1'b0;  bus.dbg_we = 1'b0;  bus.dbg_addr = '0;  bus.dbg_wdata = '0;
    rand_core(1'b0);
    @(negedge clk);
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    check_eq("rst_stall", 32'(o_stall), 32'd0);
    check_eq("rst_ack", 32'(o_ack), 32'd0);
    check_eq("rst_rdata", o_rdata, 32'd0);

    dbg_op(1'b0, 5'd1, 32'd0, 1'b0, lat, st, wr, kept);
    rd_val = o_rdata;
    check_eq("rd_r1_lat", 32'(lat), 32'd3);
    check_eq("rd_r1_stalls", 32'(st), 32'd2);
    check_eq("rd_r1_data", rd_val, 32'h4);

    dbg_op(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, lat, st, wr, kept);
    check_eq("wr_r5_lat", 32'(lat), 32'd2);
    check_eq("wr_r5_bankwr", 32'(wr), 32'd1);
    check_eq("wr_r5_stalls", 32'(st), 32'd0);
    dbg_op(1'b0, 5'd5, 32'd0, 1'b0, lat, st, wr, kept);
    check_eq("rd_r5_data", o_rdata, 32'hDEADBEEF);

    dbg_op(1'b1, 5'd0, 32'h1234, 1'b0, lat, st, wr, kept);
    check_eq("wr_r0_lat", 32'(lat), 32'd2);
    check_eq("wr_r0_bankwr", 32'(wr), 32'd0);
    dbg_op(1'b0, 5'd0, 32'd0, 1'b0, lat, st, wr, kept);
    check_eq("rd_r0_data", o_rdata, 32'd0);

    dbg_op(1'b1, 5'd9, 32'hCAFEF00D, 1'b1, lat, st, wr, kept);
    check_eq("starve_lat", 32'(lat), 32'(SM + 2));
    check_eq("starve_kept", 32'(kept), 32'(SM));
    check_eq("starve_stalls", 32'(st), 32'd1);
    check_eq("starve_bankwr", 32'(wr), 32'd1);
    dbg_op(1'b0, 5'd9, 32'd0, 1'b0, lat, st, wr, kept);
    check_eq("rd_r9_data", o_rdata, 32'hCAFEF00D);

    // Reset while the read capture is in flight.
    bus.dbg_req = 1'b1;  bus.dbg_we = 1'b0;  bus.dbg_addr = 5'd3;
    rand_core(1'b0);
    cycle();
    cycle();
    reset = 1'b1;  bus.dbg_req = 1'b0;
    cycle();
    check_eq("capt_stall", 32'(o_stall), 32'd1);
    reset = 1'b0;
    cycle();
    check_eq("abort_ack", 32'(o_ack), 32'd0);
    check_eq("abort_stall", 32'(o_stall), 32'd0);
    check_eq("abort_rdata", o_rdata, 32'd0);
    cycle();
    check_eq("abort_ack2", 32'(o_ack), 32'd0);

    stall_sum = 0;
    for (int n = 0; n < 20; n++) begin
      rand_core(1'($urandom));
      cycle();
      stall_sum += int'(o_stall);
    end
    check_eq("core_only_stalls", 32'(stall_sum), 32'd0);

    bias = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 100 == 0) bias = int'($urandom_range(0, 3));
      rand_core((bias == 3) ? 1'b1 : ($urandom_range(0, 3) < bias));
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;  bus.dbg_req = 1'b0;
      end else begin
        reset = 1'b0;
        if (bus.dbg_req && o_ack) bus.dbg_req = 1'b0;
        else if (!bus.dbg_req && $urandom_range(0, 2) == 0) begin
          bus.dbg_req = 1'b1;  bus.dbg_we = 1'($urandom);
          bus.dbg_addr = AW'($urandom);  bus.dbg_wdata = $urandom;
        end
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
